x_delay_line_meas: RTL
======================

Name: x_delay_line_meas

Overview:
- Sits directly downstream of the 32-tap delay line and consumes its per-cycle snapshot word.
- Each cycle it polarity-normalises the snapshot and encodes the edge position into a tap count.
- On request, it accumulates 2^LOG2_N samples after a settle window, then reports sum, average, min and max through a valid/ready handshake.

Parameters:
- WIDTH, 32: delay-line snapshot width (taps).
- LOG2_N, 4: log2 of samples accumulated per measurement (16).
- DISCARD, 4: encoded samples dropped after start, before accumulation; range 0..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_data  in  WIDTH  delay-line snapshot word
- i_start  in  1  measurement request pulse; sampled only in IDLE
- o_busy  out  1  high in SETTLE or ACCUM
- o_code  out  CW  live encoded tap count, CW = $clog2(WIDTH) (5)
- o_valid  out  1  result available; held until accepted
- i_ready  in  1  consumer accepts result when o_valid & i_ready
- o_sum  out  CW+LOG2_N  accumulated codes
- o_avg  out  CW  o_sum >> LOG2_N (truncating)
- o_min  out  CW  minimum code in window
- o_max  out  CW  maximum code in window

Behaviour:
- Interface fixed: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; o_min register = all-ones.
- Stage 1 (register): d1 <= i_data.
- Stage 2 (encode):
  - ref = d1[WIDTH-1]; n = d1 ^ {WIDTH{ref}}.
  - code = count of consecutive 1s in n from bit 0 upward, stopping at the first 0. Range 0..WIDTH-1, since n[WIDTH-1] is always 0.
  - o_code registered; 2-cycle latency from i_data to o_code.
- FSM states: IDLE, SETTLE, ACCUM, DONE.
- IDLE:
  - i_start -> SETTLE; load cnt = DISCARD.
  - Clear sum to 0, min to all-ones, max to 0.
  - If DISCARD == 0, go directly to ACCUM.
- SETTLE: cnt decrements each cycle; when cnt reaches 1 -> ACCUM, load cnt = 2^LOG2_N.
- ACCUM:
  - Each cycle: sum += o_code; min = min(min, o_code); max = max(max, o_code).
  - cnt decrements; after exactly 2^LOG2_N updates -> DONE.
  - sum cannot overflow: width CW+LOG2_N holds 2^LOG2_N*(WIDTH-1).
- DONE:
  - o_valid = 1; o_sum/o_avg/o_min/o_max stable.
  - On o_valid & i_ready -> IDLE, with o_valid low the next cycle; result outputs keep their last values.
- Boundary conditions:
  - i_start in SETTLE, ACCUM or DONE is ignored (not queued).
  - i_start in the same cycle as acceptance is ignored; a new request needs i_start while in IDLE.
  - i_ready without o_valid: no effect.
  - Reset mid-operation returns to IDLE immediately and drops the partial result; the pipeline regs clear.
  - Snapshot all-equal (no edge in line): code 0.
  - Bubble (e.g. n = 0b...1101_1111): first-zero rule yields 5 (without the optional feature).

Optional Feature:
- Macro: X_DL_BUBBLE_FIX_EN.
- Defined: code = popcount(n), a bubble-tolerant thermometer decode. The example bubble 0b...1101_1111 (remaining bits 0) yields 7. The encode stage gets one extra pipeline register, so latency i_data->o_code = 3 cycles.
- Undefined: first-zero encode as above, latency 2.
- FSM and handshake are identical in both cases.

Decomposition:
- Package x_delay_line_pkg:
  - typedef meas_state_t (IDLE, SETTLE, ACCUM, DONE).
  - Default constants DL_WIDTH = 32, DL_LOG2_N = 4, DL_DISCARD = 4.
  - Function clog2 helper for CW.
- One sub-module, x_delay_line_enc: polarity normalise + thermometer encode (first-zero or popcount), registered output.
- FSM and accumulator stay in the top.

Test Plan:
- Reset: hold i_rst_n=0 with i_data random -> all outputs 0; o_valid=0; o_busy=0.
- Rising edge: i_data=0x0000_07FF constant, pulse i_start -> o_busy for DISCARD+16 cycles; o_sum=176, o_avg=11, o_min=o_max=11, o_valid=1.
- Falling edge: i_data alternates 0x0000_00FF / 0xFFFF_FF00 per cycle -> every code 8; sum=128, avg=8; polarity normalisation confirmed.
- Handshake backpressure: i_ready=0 for 10 cycles after o_valid -> outputs stable, o_valid held. Then i_ready=1 with i_start=1 in the same cycle -> IDLE, no new measurement. i_start in a later cycle starts a new one.
- Min/max/bubble: codes 3..18 ramp -> min=3, max=18, sum=168, avg=10. Snapshot 0x0000_00DF -> code 5 without X_DL_BUBBLE_FIX_EN, 7 with it.
- Reset mid-ACCUM: deassert i_rst_n after 5 samples -> IDLE. The next full run's sum reflects only the new 16 samples.

Source files
------------

// File: rtl/x_delay_line_pkg.sv
// Shared types and default sizing for the delay-line measurement block.
package x_delay_line_pkg;

  localparam int DL_WIDTH   = 32;
  localparam int DL_LOG2_N  = 4;
  localparam int DL_DISCARD = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } meas_state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/x_delay_line_enc.sv
// Polarity-normalising thermometer encoder for the delay-line snapshot.
// Build option X_DL_BUBBLE_FIX_EN: popcount decode with one extra output register.
module x_delay_line_enc #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_code
);

  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] norm;
  logic [CW-1:0]    code_p1;

  // The MSB tap is the reference level; flipping against it makes the edge a rising one.
  function automatic logic [WIDTH-1:0] normalise(input logic [WIDTH-1:0] d);
    return d ^ {WIDTH{d[WIDTH-1]}};
  endfunction

  function automatic logic [CW-1:0] first_zero(input logic [WIDTH-1:0] n);
    logic [CW-1:0] c;
    logic          run;
    c   = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & n[i];
      c   = c + {{(CW-1){1'b0}}, run};
    end
    return c;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] n);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(CW-1){1'b0}}, n[i]};
    end
    return c;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] n);
`ifdef X_DL_BUBBLE_FIX_EN
    return popcount(n);
`else
    return first_zero(n);
`endif
  endfunction

  // Stage p0: capture snapshot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_p0 <= '0;
    end else begin
      data_p0 <= i_data;
    end
  end

  assign norm = normalise(data_p0);

  // Stage p1: encode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_p1 <= '0;
    end else begin
      code_p1 <= encode(norm);
    end
  end

`ifdef X_DL_BUBBLE_FIX_EN
  logic [CW-1:0] code_p2;

  // Stage p2: retime the wider popcount adder tree
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_p2 <= '0;
    end else begin
      code_p2 <= code_p1;
    end
  end

  assign o_code = code_p2;
`else
  assign o_code = code_p1;
`endif

endmodule

// File: rtl/x_delay_line_meas.sv
// Delay-line edge measurement: live tap-count code plus windowed sum/avg/min/max.
// Build option X_DL_BUBBLE_FIX_EN selects the popcount encoder (code latency 3).
module x_delay_line_meas
  import x_delay_line_pkg::*;
#(
  parameter int  WIDTH   = DL_WIDTH,
  parameter int  LOG2_N  = DL_LOG2_N,
  parameter int  DISCARD = DL_DISCARD,
  localparam int CW      = clog2(WIDTH),
  localparam int SW      = CW + LOG2_N
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_start,
  output logic             o_busy,
  output logic [CW-1:0]    o_code,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [SW-1:0]    o_sum,
  output logic [CW-1:0]    o_avg,
  output logic [CW-1:0]    o_min,
  output logic [CW-1:0]    o_max
);

  localparam int N       = 2 ** LOG2_N;
  localparam int CNT_MAX = (N > DISCARD) ? N : DISCARD;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_clr, acc_en, res_ld;

  logic [SW-1:0]    acc_sum;
  logic [CW-1:0]    acc_min, acc_max;
  logic [SW-1:0]    sum_nxt;
  logic [CW-1:0]    min_nxt, max_nxt;

  x_delay_line_enc #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_enc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .o_code  (o_code)
  );

  // Running values including the current code; also what the result latches on the last sample.
  assign sum_nxt = acc_sum + {{LOG2_N{1'b0}}, o_code};
  assign min_nxt = (o_code < acc_min) ? o_code : acc_min;
  assign max_nxt = (o_code > acc_max) ? o_code : acc_max;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    res_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          acc_clr = 1'b1;
          if (DISCARD == 0) begin
            state_d = ACCUM;
            cnt_d   = CNT_W'(N);
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(DISCARD);
          end
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACCUM;
          cnt_d   = CNT_W'(N);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          res_ld  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accumulators restart on every accepted request; results persist until the next window ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_sum <= '0;
      acc_min <= '1;
      acc_max <= '0;
      o_sum   <= '0;
      o_min   <= '0;
      o_max   <= '0;
    end else begin
      if (acc_clr) begin
        acc_sum <= '0;
        acc_min <= '1;
        acc_max <= '0;
      end else if (acc_en) begin
        acc_sum <= sum_nxt;
        acc_min <= min_nxt;
        acc_max <= max_nxt;
      end
      if (res_ld) begin
        o_sum <= sum_nxt;
        o_min <= min_nxt;
        o_max <= max_nxt;
      end
    end
  end

  assign o_avg   = o_sum[SW-1:LOG2_N];
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q == SETTLE) || (state_q == ACCUM);

endmodule
